// File: rtl/uart_rx_fifo.sv
// Receive byte buffer behind the UART receiver: captures strobed bytes into a circular
// buffer and presents them over a first-word-fall-through valid/ready interface.
module uart_rx_fifo #(
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_rx_strobe,
    input  logic [7:0]    i_rx_byte,
    input  logic          i_flush,
    input  logic [AW:0]   i_watermark,
    output logic [7:0]    o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic [AW:0]   o_count,
    output logic          o_full,
    output logic          o_wm_irq,
    output logic          o_overrun,
    input  logic          i_clr_overrun
);

    localparam logic [AW:0] LP_FULL = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          r_overrun;

    logic w_full;
    logic w_valid;
    logic w_take;
    logic w_push;
    logic w_pop;
    logic w_drop;

    always_comb begin
        w_full  = (r_count == LP_FULL);
        w_valid = (r_count != '0);
        w_take  = w_valid & i_ready;
        // Flush swallows any same-cycle push or pop, and a flushed push is not a drop.
        w_pop   = w_take & ~i_flush;
        w_push  = i_rx_strobe & ~i_flush & (~w_full | w_take);
        w_drop  = i_rx_strobe & ~i_flush & w_full & ~w_take;
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_rx_byte;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (i_flush) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + (AW + 1)'(1);
                    2'b01:   r_count <= r_count - (AW + 1)'(1);
                    default: r_count <= r_count;
                endcase
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    always_comb begin
        o_data    = w_valid ? r_mem[r_rptr] : 8'h00;
        o_valid   = w_valid;
        o_count   = r_count;
        o_full    = w_full;
        o_overrun = r_overrun;
        o_wm_irq  = (i_watermark != '0) && (r_count >= i_watermark);
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based model of the receive buffer.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk;
    logic          rst;
    logic          strobe;
    logic [7:0]    rx_byte;
    logic          flush;
    logic [AW:0]   watermark;
    logic [7:0]    data;
    logic          valid;
    logic          ready;
    logic [AW:0]   count;
    logic          full;
    logic          wm_irq;
    logic          overrun;
    logic          clr;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    logic [7:0] m_q[$];
    logic       m_ovr;

    uart_rx_fifo #(.DEPTH(DEPTH)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_rx_strobe  (strobe),
        .i_rx_byte    (rx_byte),
        .i_flush      (flush),
        .i_watermark  (watermark),
        .o_data       (data),
        .o_valid      (valid),
        .i_ready      (ready),
        .o_count      (count),
        .o_full       (full),
        .o_wm_irq     (wm_irq),
        .o_overrun    (overrun),
        .i_clr_overrun(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic model_wm();
        return (watermark != 0) && (m_q.size() >= int'(watermark));
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle after it.
    task automatic cycle(input logic s, input logic [7:0] b, input logic r, input logic f,
                         input logic c);
        logic pop;
        logic drop;
        strobe  = s;
        rx_byte = b;
        ready   = r;
        flush   = f;
        clr     = c;
        pop  = (m_q.size() > 0) && r;
        drop = 1'b0;
        if (f) begin
            m_q.delete();
        end else begin
            if (s && !(m_q.size() < DEPTH || pop)) drop = 1'b1;
            if (pop) void'(m_q.pop_front());
            if (s && !drop) m_q.push_back(b);
        end
        if (drop) m_ovr = 1'b1;
        else if (c) m_ovr = 1'b0;
        @(posedge clk);
        #1;
        strobe = 1'b0;
        ready  = 1'b0;
        flush  = 1'b0;
        clr    = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (count !== 5'd5) begin
            n_fail++;
            $display("FAIL pre_reset_count got=%0d exp=5", count);
        end
        rst = 1'b1;
        #1;
        m_q.delete();
        m_ovr = 1'b0;
        n_tests++;
        if (valid !== 1'b0 || count !== 5'd0 || overrun !== 1'b0 || full !== 1'b0 ||
            wm_irq !== 1'b0 || data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs got v=%b c=%0d o=%b f=%b w=%b d=%h exp 0",
                     valid, count, overrun, full, wm_irq, data);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_valid got=%b exp=0", valid);
        end
        cycle(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (valid !== 1'b1 || data !== 8'hA5) begin
            n_fail++;
            $display("FAIL first_byte got v=%b d=%h exp v=1 d=a5", valid, data);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_fill_wrap();
        int pops;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (full !== 1'b1 || count !== 5'd16) begin
            n_fail++;
            $display("FAIL fill got full=%b count=%0d exp full=1 count=16", full, count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++;
            if (valid !== 1'b1 || data !== 8'(i)) begin
                n_fail++;
                $display("FAIL drain[%0d] got v=%b d=%h exp v=1 d=%h", i, valid, data, 8'(i));
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        n_tests++;
        if (valid !== 1'b0 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL drained got v=%b c=%0d exp v=0 c=0", valid, count);
        end
        pops = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'($urandom), ($urandom_range(0, 2) != 0), 1'b0, 1'b0);
            n_tests++;
            if (count !== 5'(m_q.size()) || valid !== (m_q.size() > 0) ||
                (m_q.size() > 0 && data !== m_q[0])) begin
                n_fail++;
                $display("FAIL wrap[%0d] got c=%0d v=%b d=%h exp c=%0d", i, count, valid, data,
                         m_q.size());
            end
        end
        while (m_q.size() > 0 && pops < 40) begin
            n_tests++;
            if (data !== m_q[0]) begin
                n_fail++;
                $display("FAIL wrap_drain got d=%h exp d=%h", data, m_q[0]);
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            pops++;
        end
    endtask

    task automatic test_overrun();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (overrun !== 1'b1 || count !== 5'd16) begin
            n_fail++;
            $display("FAIL drop got ovr=%b c=%0d exp ovr=1 c=16", overrun, count);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_overrun got=%b exp=0", overrun);
        end
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
        n_tests++;
        if (overrun !== 1'b1 || count !== 5'd16) begin
            n_fail++;
            $display("FAIL set_beats_clr got ovr=%b c=%0d exp ovr=1 c=16", overrun, count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            n_tests++;
            if (data !== 8'(8'h40 + i)) begin
                n_fail++;
                $display("FAIL ovr_drain[%0d] got=%h exp=%h", i, data, 8'(8'h40 + i));
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
        n_tests++;
        if (valid !== 1'b0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_end got v=%b ovr=%b exp v=0 ovr=1", valid, overrun);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (count !== 5'd16 || overrun !== 1'b0 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pushpop got c=%0d ovr=%b f=%b exp c=16 ovr=0 f=1", count,
                     overrun, full);
        end
        for (int i = 0; i < DEPTH; i++) begin
            exp = (i < DEPTH - 1) ? 8'(8'h11 + i) : 8'h55;
            n_tests++;
            if (data !== exp) begin
                n_fail++;
                $display("FAIL pp_drain[%0d] got=%h exp=%h", i, data, exp);
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        while (m_q.size() > 7) cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (count !== 5'd7 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_flush got c=%0d ovr=%b exp c=7 ovr=1", count, overrun);
        end
        cycle(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (count !== 5'd0 || valid !== 1'b0 || overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL flush got c=%0d v=%b ovr=%b exp c=0 v=0 ovr=1", count, valid,
                     overrun);
        end
        // Flush of a full buffer with a strobe must not raise overrun.
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
        n_tests++;
        if (count !== 5'd0 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_full got c=%0d ovr=%b exp c=0 ovr=0", count, overrun);
        end
        cycle(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (valid !== 1'b1 || data !== 8'h3C || count !== 5'd1) begin
            n_fail++;
            $display("FAIL after_flush got v=%b d=%h c=%0d exp v=1 d=3c c=1", valid, data, count);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_watermark();
        watermark = 5'd4;
        #1;
        for (int i = 1; i <= 5; i++) begin
            cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            n_tests++;
            if (wm_irq !== (i >= 4)) begin
                n_fail++;
                $display("FAIL wm4_up[%0d] got=%b exp=%b", i, wm_irq, (i >= 4));
            end
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (wm_irq !== 1'b1) begin
            n_fail++;
            $display("FAIL wm4_at4 got=%b exp=1", wm_irq);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (wm_irq !== 1'b0 || count !== 5'd3) begin
            n_fail++;
            $display("FAIL wm4_fall got w=%b c=%0d exp w=0 c=3", wm_irq, count);
        end
        for (int w = 0; w <= 17; w += 17) begin
            watermark = 5'(w);
            cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
            for (int i = 0; i <= DEPTH; i++) begin
                n_tests++;
                if (wm_irq !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wm%0d_never at c=%0d got=1 exp=0", w, count);
                end
                if (i < DEPTH) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
            end
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) watermark = 5'($urandom_range(0, 18));
            cycle(($urandom_range(0, 2) != 0), 8'($urandom), ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0));
            n_tests++;
            if (count !== 5'(m_q.size()) || valid !== (m_q.size() > 0) ||
                full !== (m_q.size() == DEPTH) || overrun !== m_ovr ||
                wm_irq !== model_wm() || (m_q.size() > 0 && data !== m_q[0])) begin
                n_fail++;
                $display("FAIL random[%0d] got c=%0d v=%b f=%b o=%b w=%b d=%h exp c=%0d o=%b w=%b",
                         i, count, valid, full, overrun, wm_irq, data, m_q.size(), m_ovr,
                         model_wm());
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        strobe    = 1'b0;
        rx_byte   = 8'h00;
        flush     = 1'b0;
        watermark = 5'd0;
        ready     = 1'b0;
        clr       = 1'b0;
        m_ovr     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        test_reset();
        test_fill_wrap();
        test_overrun();
        test_full_push_pop();
        test_flush();
        test_watermark();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer directly downstream of the UART receiver.
- Captures each received byte on the receiver's one-cycle byte-done strobe and holds it in a circular buffer.
- Presents bytes to the bus/CPU side over a first-word-fall-through valid/ready interface.
- Reports fill level, a watermark interrupt, and a sticky overrun flag when bytes arrive while the buffer is full.

Parameters:
- DEPTH, 16, number of byte entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width (derived; not overridden).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-high.
- i_rx_strobe  in  1  byte-done pulse from the receiver; each high cycle is one write.
- i_rx_byte  in  8  received byte; valid in any cycle where i_rx_strobe=1.
- i_flush  in  1  synchronous clear of buffer contents.
- i_watermark  in  AW+1  threshold level for o_wm_irq.
- o_data  out  8  head byte; valid when o_valid=1.
- o_valid  out  1  buffer non-empty.
- i_ready  in  1  consumer accepts head byte; a pop occurs on o_valid & i_ready.
- o_count  out  AW+1  current occupancy, 0..DEPTH.
- o_full  out  1  o_count == DEPTH.
- o_wm_irq  out  1  o_count >= i_watermark and i_watermark != 0.
- o_overrun  out  1  sticky; a byte was dropped.
- i_clr_overrun  in  1  clears o_overrun.

Behaviour:
- Reset (i_rst high, asynchronous) clears read/write pointers, count and overrun.
  - Outputs during reset: o_valid=0, o_count=0, o_full=0, o_wm_irq=0, o_overrun=0.
  - o_data during reset is don't-care; implementation drives 0.
  - Storage array is not reset.
- Pointers are AW-bit and wrap modulo DEPTH. Occupancy is a separate AW+1-bit counter. Full and empty are derived from the counter only.
- Push: i_rx_strobe=1 and (count<DEPTH or pop this cycle).
  - Writes i_rx_byte at wptr.
  - wptr increments.
- Pop: o_valid=1 and i_ready=1.
  - rptr increments.
  - o_data shows the next entry in the following cycle.
- Empty-to-valid latency: a push into an empty buffer in cycle N gives o_valid=1 and o_data=byte in cycle N+1. There is no same-cycle bypass.
- o_data is read combinationally from array[rptr] (first-word fall-through).
- Count update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - neither: unchanged.
- Full with simultaneous push and pop: push accepted, count stays DEPTH, no overrun.
- Full with push and no pop:
  - byte dropped; array and pointers unchanged.
  - o_overrun=1 from the next cycle.
- Empty with i_ready=1: no pop, rptr unchanged.
- Overrun flag:
  - Set on a dropped byte.
  - Cleared by i_clr_overrun.
  - If set and clear occur in the same cycle, set wins.
  - Not affected by i_flush.
- Flush:
  - i_flush=1 zeroes rptr, wptr and count next cycle.
  - Flush has priority over a same-cycle push or pop; that push is discarded and does not set overrun.
- Watermark:
  - o_wm_irq is combinational from registered count and i_watermark.
  - i_watermark=0 disables it.
  - i_watermark>DEPTH never asserts.
- Strobe assumption: the strobe is at most one cycle per received byte. Back-to-back strobe cycles are legal and each is a separate write.
- All outputs are registered state or pure combinational decode of registered state. No input-to-output combinational path except the watermark compare.

Test Plan:
- Reset then idle: assert i_rst mid-run with count=5 -> same cycle o_valid=0, o_count=0, o_overrun=0; after release, a strobe with 0xA5 -> o_valid=1, o_data=0xA5 exactly one cycle later.
- Fill/wrap, DEPTH=16: push 0x00..0x0F with i_ready=0 -> o_full=1, o_count=16; drain with i_ready=1 -> o_data sequence 0x00..0x0F; then push 20 more interleaved with pops -> order preserved across pointer wrap.
- Overrun: full buffer, strobe 0xEE with i_ready=0 -> o_overrun=1 next cycle, o_count stays 16, 0xEE never appears; i_clr_overrun alone -> 0; clear together with a new drop -> stays 1.
- Full with simultaneous push and pop: full, strobe 0x55 with i_ready=1 -> o_count stays 16, no overrun, 0x55 emerges 16th after.
- Flush priority: count=7, i_flush with strobe and i_ready in the same cycle -> next cycle o_count=0, o_valid=0, o_overrun unchanged.
- Watermark: i_watermark=4 -> o_wm_irq rises the cycle o_count becomes 4 and falls when a pop makes it 3; i_watermark=0 -> never asserts at any count.
